// File: rtl/tilt_ratio_arbiter.sv
// Orders each per-channel (distance, height) pair into a ratio <= 1, holds one pending result per channel,
// and round-robins the pending results into the shared tilt divider over valid/ready.
module tilt_ratio_arbiter #(
  parameter int WIDTH     = 12,
  parameter int CHANNELS  = 4,
  parameter int CHAN_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sqrt_ready,
  input  logic [CHAN_BITS-1:0]      sqrt_chan,
  input  logic [WIDTH-1:0]          sqrt_out,
  input  logic [CHANNELS*WIDTH-1:0] heights,
  input  logic                      div_ready,
  output logic                      div_valid,
  output logic [WIDTH-1:0]          tilt_dividend,
  output logic [WIDTH-1:0]          tilt_divisor,
  output logic                      d_greater_than_h,
  output logic                      degenerate,
  output logic [CHAN_BITS-1:0]      tilt_chan,
  output logic [CHANNELS-1:0]       overrun
);

  typedef struct packed {
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flag;
    logic             degen;
  } payload_t;

  payload_t             slot [CHANNELS];
  logic [CHANNELS-1:0]  pend;
  logic [CHANNELS-1:0]  pend_next;
  logic [CHAN_BITS-1:0] last_grant;
  logic [CHAN_BITS-1:0] grant;
  logic                 grant_found;
  logic                 capture;
  logic                 dispatch;
  logic [WIDTH-1:0]     cap_height;
  payload_t             cap_payload;

  assign capture = sqrt_ready && (int'(sqrt_chan) < CHANNELS);

  always_comb begin
    cap_height = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sqrt_chan) == i) cap_height = heights[i*WIDTH +: WIDTH];
    end
    cap_payload = '0;
    if (sqrt_out > cap_height) begin
      cap_payload.dividend = cap_height;
      cap_payload.divisor  = sqrt_out;
      cap_payload.flag     = 1'b1;
    end else begin
      cap_payload.dividend = sqrt_out;
      cap_payload.divisor  = cap_height;
      cap_payload.flag     = 1'b0;
    end
    cap_payload.degen = (cap_payload.divisor == '0);
  end

  // Round-robin search over the registered pend vector, starting after last_grant.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!grant_found && pend[(int'(last_grant) + k) % CHANNELS]) begin
        grant_found = 1'b1;
        grant       = CHAN_BITS'((int'(last_grant) + k) % CHANNELS);
      end
    end
  end

  assign dispatch = (!div_valid || div_ready) && grant_found;

  always_comb begin
    pend_next = pend;
    if (dispatch) pend_next[grant] = 1'b0;
    if (capture)  pend_next[sqrt_chan] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_valid        <= 1'b0;
      tilt_dividend    <= '0;
      tilt_divisor     <= '0;
      d_greater_than_h <= 1'b0;
      degenerate       <= 1'b0;
      tilt_chan        <= '0;
      overrun          <= '0;
      pend             <= '0;
      last_grant       <= CHAN_BITS'(CHANNELS - 1);
      for (int i = 0; i < CHANNELS; i++) slot[i] <= '0;
    end else begin
      if (dispatch) begin
        div_valid        <= 1'b1;
        tilt_dividend    <= slot[grant].dividend;
        tilt_divisor     <= slot[grant].divisor;
        d_greater_than_h <= slot[grant].flag;
        degenerate       <= slot[grant].degen;
        tilt_chan        <= grant;
        last_grant       <= grant;
      end else if (div_ready) begin
        div_valid <= 1'b0;
      end
      pend <= pend_next;
      // A capture racing the dispatch of its own channel is a hand-off, not a loss.
      if (capture) begin
        slot[sqrt_chan] <= cap_payload;
        if (pend[sqrt_chan] && !(dispatch && grant == sqrt_chan)) overrun[sqrt_chan] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tilt_ratio_arbiter.sv
// Directed scenarios plus randomized traffic checked against a per-cycle behavioural model of the arbiter.
module tb_tilt_ratio_arbiter;

  localparam int W  = 12;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sqrt_ready = 1'b0;
  logic [1:0]    sqrt_chan = '0;
  logic [W-1:0]  sqrt_out = '0;
  logic [CH*W-1:0] heights = '0;
  logic          div_ready = 1'b0;
  logic          div_valid;
  logic [W-1:0]  tilt_dividend;
  logic [W-1:0]  tilt_divisor;
  logic          d_greater_than_h;
  logic          degenerate;
  logic [1:0]    tilt_chan;
  logic [CH-1:0] overrun;

  tilt_ratio_arbiter #(.WIDTH(W), .CHANNELS(CH), .CHAN_BITS(2)) dut (
    .clk(clk), .reset(reset), .sqrt_ready(sqrt_ready), .sqrt_chan(sqrt_chan),
    .sqrt_out(sqrt_out), .heights(heights), .div_ready(div_ready),
    .div_valid(div_valid), .tilt_dividend(tilt_dividend), .tilt_divisor(tilt_divisor),
    .d_greater_than_h(d_greater_than_h), .degenerate(degenerate),
    .tilt_chan(tilt_chan), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int hv [CH];
  int m_dvd [CH];
  int m_dvs [CH];
  bit m_flag [CH];
  bit m_pend [CH];
  int m_last;
  bit m_vld;
  int o_dvd, o_dvs, o_ch;
  bit o_flag;
  bit [CH-1:0] m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_height(input int c, input int v);
    hv[c] = v;
    heights[c*W +: W] = W'(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = 0; m_dvd[i] = 0; m_dvs[i] = 0; m_flag[i] = 0;
    end
    m_last = CH - 1; m_vld = 0; m_ovr = '0;
    o_dvd = 0; o_dvs = 0; o_ch = 0; o_flag = 0;
  endtask

  task automatic model_update(input bit rdy, input int c, input int d, input bit dr);
    int g;
    bit disp;
    g = -1;
    for (int k = 1; k <= CH; k++) begin
      if (g < 0 && m_pend[(m_last + k) % CH]) g = (m_last + k) % CH;
    end
    disp = (!m_vld || dr) && (g >= 0);
    if (disp) begin
      m_vld = 1; o_dvd = m_dvd[g]; o_dvs = m_dvs[g]; o_flag = m_flag[g]; o_ch = g;
      m_last = g; m_pend[g] = 0;
    end else if (m_vld && dr) begin
      m_vld = 0;
    end
    if (rdy && c < CH) begin
      if (m_pend[c] && !(disp && g == c)) m_ovr[c] = 1'b1;
      m_flag[c] = d > hv[c];
      m_dvd[c]  = (d > hv[c]) ? hv[c] : d;
      m_dvs[c]  = (d > hv[c]) ? d : hv[c];
      m_pend[c] = 1;
    end
  endtask

  task automatic compare_model();
    check("valid", div_valid, m_vld);
    check("overrun", overrun, m_ovr);
    if (m_vld) begin
      check("dividend", tilt_dividend, o_dvd);
      check("divisor", tilt_divisor, o_dvs);
      check("flag", d_greater_than_h, o_flag);
      check("degenerate", degenerate, o_dvs == 0);
      check("chan", tilt_chan, o_ch);
    end
  endtask

  // Drive one cycle of inputs at a negedge, then compare at the following negedge.
  task automatic step(input bit rdy, input int c, input int d, input bit dr);
    sqrt_ready = rdy; sqrt_chan = 2'(c); sqrt_out = W'(d); div_ready = dr;
    model_update(rdy, c, d, dr);
    @(negedge clk);
    compare_model();
  endtask

  task automatic expect_out(input string tag, input int dvd, input int dvs, input bit fl, input bit dg, input int c);
    check({tag, "_valid"}, div_valid, 1);
    check({tag, "_dividend"}, tilt_dividend, dvd);
    check({tag, "_divisor"}, tilt_divisor, dvs);
    check({tag, "_flag"}, d_greater_than_h, fl);
    check({tag, "_degen"}, degenerate, dg);
    check({tag, "_chan"}, tilt_chan, c);
  endtask

  task automatic do_reset();
    reset = 1'b0; sqrt_ready = 0; div_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < CH; i++) set_height(i, 0);
    do_reset();
    check("rst_valid", div_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_chan", tilt_chan, 0);
    check("rst_dividend", tilt_dividend, 0);

    // single capture
    set_height(2, 200);
    step(1, 2, 300, 1);
    check("single_lat", div_valid, 0);
    step(0, 0, 0, 1);
    expect_out("single", 200, 300, 1, 0, 2);
    step(0, 0, 0, 1);
    check("single_drain", div_valid, 0);

    // equality and zero
    set_height(0, 150);
    set_height(1, 0);
    step(1, 0, 150, 1);
    step(1, 1, 0, 1);
    expect_out("equal", 150, 150, 0, 0, 0);
    step(0, 0, 0, 1);
    expect_out("zero", 0, 0, 0, 1, 1);
    step(0, 0, 0, 1);
    check("zero_drain", div_valid, 0);

    // round robin under backpressure
    step(1, 3, 77, 0);
    step(1, 0, 5, 0);
    check("rr_first_chan", tilt_chan, 3);
    step(1, 1, 9, 0);
    check("rr_hold_valid", div_valid, 1);
    check("rr_hold_chan", tilt_chan, 3);
    step(0, 0, 0, 1);
    check("rr_second", tilt_chan, 0);
    step(0, 0, 0, 1);
    check("rr_third", tilt_chan, 1);
    step(0, 0, 0, 1);
    check("rr_done", div_valid, 0);

    // overrun
    set_height(1, 250);
    step(1, 0, 50, 0);
    step(0, 0, 0, 0);
    check("ovr_full_chan0", tilt_chan, 0);
    step(1, 1, 100, 0);
    step(1, 1, 400, 0);
    check("ovr_flags", overrun, 4'b0010);
    step(0, 0, 0, 1);
    expect_out("ovr_deliver", 250, 400, 1, 0, 1);
    step(0, 0, 0, 1);

    // simultaneous capture and dispatch on channel 2
    set_height(2, 20);
    step(1, 2, 10, 1);
    set_height(2, 30);
    step(1, 2, 40, 1);
    expect_out("simul_old", 10, 20, 0, 0, 2);
    step(0, 0, 0, 1);
    expect_out("simul_new", 30, 40, 1, 0, 2);
    check("simul_ovr2", overrun[2], 0);
    step(0, 0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 31) == 0) begin
        int c, v;
        c = $urandom_range(0, CH - 1);
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 4095);
        set_height(c, v);
      end
      begin
        int d, c;
        c = $urandom_range(0, CH - 1);
        case ($urandom_range(0, 3))
          0: d = hv[c];
          1: d = $urandom_range(0, 2);
          default: d = $urandom_range(0, 4095);
        endcase
        step($urandom_range(0, 1), c, d, $urandom_range(0, 2) != 0);
      end
    end

    // asynchronous reset while a request is held
    set_height(3, 100);
    step(1, 3, 500, 0);
    step(0, 0, 0, 0);
    check("arst_pre_valid", div_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", div_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_dividend", tilt_dividend, 0);
    check("arst_divisor", tilt_divisor, 0);
    check("arst_chan", tilt_chan, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    check("arst_idle", div_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tilt_ratio_arbiter.md
# tilt_ratio_arbiter

Parametrised, multi-channel successor to the single-fixture tilt normaliser. It takes square-root results (horizontal distance) tagged by channel and compares each with that channel's mounting height. It orders each pair so the ratio is at most 1 and buffers one pending result per channel. A round-robin arbiter then feeds the results, one at a time, into the shared tilt divider over a valid/ready handshake.

## Interface
- WIDTH, 12, width of distance, height, dividend and divisor
- CHANNELS, 4, number of fixtures/channels (2..16)
- CHAN_BITS, 2, width of channel index; must be ≥ clog2(CHANNELS)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- sqrt_ready  in  1  one-cycle strobe: sqrt_out/sqrt_chan valid
- sqrt_chan  in  CHAN_BITS  channel of current sqrt result
- sqrt_out  in  WIDTH  unsigned horizontal distance
- heights  in  CHANNELS*WIDTH  channel i height at [i*WIDTH +: WIDTH], quasi-static
- div_ready  in  1  divider accepts a request this cycle
- div_valid  out  1  request valid
- tilt_dividend  out  WIDTH  smaller operand
- tilt_divisor  out  WIDTH  larger operand
- d_greater_than_h  out  1  1 when distance strictly greater than height
- degenerate  out  1  1 when divisor is zero (both operands zero)
- tilt_chan  out  CHAN_BITS  channel of current request
- overrun  out  CHANNELS  sticky per-channel overwrite flags

## Operation
- Capture: on sqrt_ready with sqrt_chan < CHANNELS, h = heights[sqrt_chan], compared unsigned.
  - sqrt_out > h: slot gets dividend=h, divisor=sqrt_out, flag=1.
  - Otherwise, including equality: dividend=sqrt_out, divisor=h, flag=0.
  - degenerate = (divisor == 0).
  - The payload is written to slot[sqrt_chan] and pend[sqrt_chan] is set.
- sqrt_chan ≥ CHANNELS: strobe ignored; no state change.
- Overwrite: capture to a channel with pend=1 that is not being dispatched in the same cycle overwrites the slot (latest wins) and sets overrun[chan]. overrun clears only on reset.
- Output register has two states:
  - EMPTY (div_valid=0).
  - FULL (div_valid=1). Fields are held stable until div_valid && div_ready.
- Dispatch: when the output register is EMPTY or transferring this cycle and any pend bit is set, the round-robin arbiter grants the first pending channel, searching from last_grant+1 modulo CHANNELS. Its slot is loaded into the output register, pend cleared, last_grant updated, state FULL.
- Transfer with no pending channel: state EMPTY.
- Same-cycle capture and dispatch on the same channel: the old slot contents are dispatched and the new payload is stored. pend stays 1 and no overrun is flagged.
- The arbiter sees pend as registered at the start of the cycle. A capture is never dispatched in the cycle it arrives.

## Timing
- Reset (async assert, sync-safe release):
  - all outputs 0 (div_valid, fields, tilt_chan, overrun);
  - all pend 0;
  - last_grant = CHANNELS-1, so channel 0 has first priority.
- Latency: a strobe in cycle N with an idle output gives div_valid=1 from cycle N+1 (visible after the second rising edge).
- Throughput: one request per cycle while div_ready=1 and channels are pending; back-to-back transfers with no bubble.
- Backpressure: with div_ready=0, all outputs are frozen and captures continue into slots.
- Reset mid-transfer discards the output register and all slots immediately.

## Test plan
All scenarios use WIDTH=12, CHANNELS=4.
- Reset: assert reset low mid-run with div_valid=1 -> all outputs 0 asynchronously. After release and no strobes, div_valid stays 0.
- Single capture: chan 2, sqrt_out 300, height[2]=200, div_ready=1 -> next cycle div_valid=1, dividend 200, divisor 300, flag 1, degenerate 0, tilt_chan 2. Transfer then div_valid=0.
- Equal and zero:
  - chan 0, 150/150 -> dividend 150, divisor 150, flag 0.
  - chan 1, 0/0 -> degenerate 1, flag 0.
- Round-robin with backpressure: div_ready=0; capture chan 3, 0, 1 in consecutive cycles -> output holds chan 3 stable. Raise div_ready -> chan 3, 0, 1 transfer in consecutive cycles, then div_valid=0.
- Overrun: div_ready=0, output FULL with chan 0; two captures on chan 1 (sqrt_out 100 then 400, height 250) -> overrun=4'b0010. Chan 1 is later delivered as dividend 250, divisor 400, flag 1.
- Simultaneous capture and dispatch: chan 2 pending (dividend 10, divisor 20) is dispatched while a new chan-2 capture (dividend 30, divisor 40) arrives -> first transfer 10/20, second 30/40, overrun[2]=0.
